irq_encoder83: RTL and testbench



---
 rtl/irq_pkg.sv | 12 +
 rtl/prio_enc8.sv | 20 ++
 rtl/irq_encoder83.sv | 68 ++++++
 tb/tb_irq_encoder83.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and FSM state type for the interrupt encoder
package irq_pkg;

  localparam int NUM_SRC = 8;
  localparam int CODE_W  = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

endpackage

// File: rtl/prio_enc8.sv
// rtl/prio_enc8.sv - combinational 8-to-3 priority encoder, bit 7 highest
module prio_enc8
  import irq_pkg::*;
(
  input  logic [NUM_SRC-1:0] in_i,
  output logic [CODE_W-1:0]  idx_o,
  output logic               any_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (in_i[i]) idx_o = CODE_W'(i);
    end
  end

  assign any_o = |in_i;

endmodule

// File: rtl/irq_encoder83.sv
// rtl/irq_encoder83.sv - registered 8-to-3 interrupt priority encoder with pending/mask and valid/ack
module irq_encoder83
  import irq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] mask,
  input  logic               ack,
  output logic               irq_valid,
  output logic [CODE_W-1:0]  irq_code,
  output logic [NUM_SRC-1:0] pending
);

  irq_state_t         state_q, state_d;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] clr;
  logic [CODE_W-1:0]  enc_idx;
  logic               enc_any;

  prio_enc8 u_prio_enc8 (
    .in_i  (pend_q & ~mask),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Request is OR-ed in after the clear so a same-cycle re-request survives the ack.
  always_comb begin
    clr = '0;
    if (state_q == PRESENT && ack) clr[code_q] = 1'b1;
    pend_d = (pend_q & ~clr) | req;
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = PRESENT;
          code_d  = enc_idx;
        end
      end
      PRESENT: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      code_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= pend_d;
    end
  end

  assign irq_valid = (state_q == PRESENT);
  assign irq_code  = code_q;
  assign pending   = pend_q;

endmodule

// File: tb/tb_irq_encoder83.sv
// tb/tb_irq_encoder83.sv - self-checking bench for irq_encoder83
module tb_irq_encoder83;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = '0;
  logic [7:0] mask = '0;
  logic       ack = 1'b0;
  logic       irq_valid;
  logic [2:0] irq_code;
  logic [7:0] pending;

  int n_checks = 0;
  int n_fails  = 0;

  bit [7:0] m_pend;
  bit       m_valid;
  int       m_code;

  irq_encoder83 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask      (mask),
    .ack       (ack),
    .irq_valid (irq_valid),
    .irq_code  (irq_code),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  function automatic int highest(bit [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, "_valid"}, {7'd0, irq_valid}, {7'd0, m_valid});
    chk({tag, "_code"}, {5'd0, irq_code}, 8'(m_code));
    chk({tag, "_pend"}, pending, m_pend);
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_code  = 0;
  endtask

  // One clock: predict from the rules, advance, then compare just after the edge.
  task automatic step(string tag);
    bit [7:0] kept;
    bit       n_valid;
    int       n_code;
    int       h;
    kept    = m_pend;
    n_valid = m_valid;
    n_code  = m_code;
    if (m_valid && ack) begin
      kept[m_code] = 1'b0;
      n_valid      = 1'b0;
    end
    if (!m_valid) begin
      h = highest(m_pend & ~mask);
      if (h >= 0) begin
        n_valid = 1'b1;
        n_code  = h;
      end
    end
    @(posedge clk);
    #1;
    m_pend  = kept | req;
    m_valid = n_valid;
    m_code  = n_code;
    chk_model(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {7'd0, irq_valid}, 8'h00);
    chk("rst_code", {5'd0, irq_code}, 8'h00);
    chk("rst_pend", pending, 8'h00);
    rst_n = 1'b1;
    step("idle");

    req = 8'h04; step("t1_req");
    chk("t1_pend", pending, 8'h04);
    req = 8'h00; step("t1_pres");
    chk("t1_code", {5'd0, irq_code}, 8'd2);
    ack = 1'b1; step("t1_ack");
    ack = 1'b0;
    chk("t1_clear", pending, 8'h00);

    req = 8'h81; step("t2_req");
    req = 8'h00; step("t2_p7");
    chk("t2_code7", {5'd0, irq_code}, 8'd7);
    ack = 1'b1; step("t2_ack7");
    chk("t2_gap", {7'd0, irq_valid}, 8'h00);
    ack = 1'b0; step("t2_p0");
    chk("t2_code0", {5'd0, irq_code}, 8'd0);
    ack = 1'b1; step("t2_ack0");
    ack = 1'b0;
    chk("t2_empty", pending, 8'h00);

    req = 8'h04; step("t3_req");
    req = 8'h00; step("t3_p2");
    req = 8'h40; step("t3_hi");
    req = 8'h00; step("t3_hold");
    chk("t3_held", {5'd0, irq_code}, 8'd2);
    ack = 1'b1; step("t3_ack2");
    ack = 1'b0; step("t3_p6");
    chk("t3_code6", {5'd0, irq_code}, 8'd6);
    ack = 1'b1; step("t3_ack6");
    ack = 1'b0;

    mask = 8'h80; req = 8'h81; step("t4_req");
    req = 8'h00; step("t4_p0");
    chk("t4_code0", {5'd0, irq_code}, 8'd0);
    ack = 1'b1; step("t4_ack0");
    ack = 1'b0;
    chk("t4_masked", pending, 8'h80);
    mask = 8'h00; step("t4_unmask");
    chk("t4_code7", {5'd0, irq_code}, 8'd7);
    ack = 1'b1; step("t4_ack7");
    ack = 1'b0;

    req = 8'h08; step("t5_req");
    req = 8'h00; step("t5_p3");
    ack = 1'b1; req = 8'h08; step("t5_coll");
    chk("t5_kept", pending, 8'h08);
    ack = 1'b0; req = 8'h00; step("t5_re");
    chk("t5_code3", {5'd0, irq_code}, 8'd3);
    chk("t5_valid", {7'd0, irq_valid}, 8'h01);
    ack = 1'b1; step("t5_ack");
    ack = 1'b0;

    req = 8'h0F; step("t6_req");
    req = 8'h00; step("t6_pres");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_async_valid", {7'd0, irq_valid}, 8'h00);
    chk("t6_async_code", {5'd0, irq_code}, 8'h00);
    chk("t6_async_pend", pending, 8'h00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) step("t6_quiet");

    for (int i = 0; i < 400; i++) begin
      req  = (($urandom % 4) == 0) ? 8'($urandom) & 8'($urandom) : 8'h00;
      mask = (($urandom % 8) == 0) ? 8'($urandom) : mask;
      ack  = (($urandom % 3) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
